// File: rtl/instr_decode_if.sv
// Decode-stage bus: fetch/write-back inputs toward the decoder and the ID/EX outputs back.
interface instr_decode_if;
    logic [31:0] pc_next_in;
    logic [31:0] instruction;
    logic        stall;
    logic        flush;
    logic        reg_write_wb;
    logic [4:0]  write_reg_wb;
    logic [31:0] write_data_wb;

    logic [31:0] pc_next_out;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [31:0] sign_ext_imm;
    logic [4:0]  rt_out;
    logic [4:0]  rd_out;
    logic        reg_dst;
    logic        alu_src;
    logic        mem_to_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic [1:0]  alu_op;

    modport master (
        output pc_next_in, instruction, stall, flush, reg_write_wb, write_reg_wb, write_data_wb,
        input  pc_next_out, read_data1, read_data2, sign_ext_imm, rt_out, rd_out,
               reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op
    );

    modport slave (
        input  pc_next_in, instruction, stall, flush, reg_write_wb, write_reg_wb, write_data_wb,
        output pc_next_out, read_data1, read_data2, sign_ext_imm, rt_out, rd_out,
               reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op
    );
endinterface

// File: rtl/instr_decode.sv
// MIPS-style decode stage: control decode, 32x32 register file with write-back bypass,
// and the ID/EX pipeline register with stall/flush.
module instr_decode (
    input logic          clk,
    input logic          reset,
    instr_decode_if.slave id
);
    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    logic [31:0] rf [32];
    logic [4:0]  rs, rt;
    logic        wb_en;
    logic [31:0] rd1, rd2;
    ctrl_t       ctrl_d, ctrl_q;
    logic [31:0] pc_q, rd1_q, rd2_q, imm_q;
    logic [4:0]  rt_q, rd_q;

    assign rs    = id.instruction[25:21];
    assign rt    = id.instruction[20:16];
    assign wb_en = id.reg_write_wb && (id.write_reg_wb != 5'd0);

    always_comb begin
        ctrl_d = '0;
        unique case (id.instruction[31:26])
            6'h00: begin ctrl_d.reg_dst = 1'b1; ctrl_d.reg_write = 1'b1; ctrl_d.alu_op = 2'b10; end
            6'h23: begin
                ctrl_d.alu_src  = 1'b1; ctrl_d.mem_to_reg = 1'b1;
                ctrl_d.reg_write = 1'b1; ctrl_d.mem_read  = 1'b1;
            end
            6'h2B: begin ctrl_d.alu_src = 1'b1; ctrl_d.mem_write = 1'b1; end
            6'h04: begin ctrl_d.branch = 1'b1; ctrl_d.alu_op = 2'b01; end
            6'h08: begin ctrl_d.alu_src = 1'b1; ctrl_d.reg_write = 1'b1; end
            default: ctrl_d = '0;
        endcase
    end

    // Same-cycle write-back is forwarded so the reader never sees the stale entry.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rs != 5'd0) rd1 = (wb_en && id.write_reg_wb == rs) ? id.write_data_wb : rf[rs];
        if (rt != 5'd0) rd2 = (wb_en && id.write_reg_wb == rt) ? id.write_data_wb : rf[rt];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (wb_en) begin
            rf[id.write_reg_wb] <= id.write_data_wb;
        end
    end

    // Flush beats stall: controls become a bubble while data still loads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q <= '0;
            pc_q   <= '0;
            rd1_q  <= '0;
            rd2_q  <= '0;
            imm_q  <= '0;
            rt_q   <= '0;
            rd_q   <= '0;
        end else if (id.flush || !id.stall) begin
            ctrl_q <= id.flush ? ctrl_t'('0) : ctrl_d;
            pc_q   <= id.pc_next_in;
            rd1_q  <= rd1;
            rd2_q  <= rd2;
            imm_q  <= {{16{id.instruction[15]}}, id.instruction[15:0]};
            rt_q   <= rt;
            rd_q   <= id.instruction[15:11];
        end
    end

    assign id.pc_next_out  = pc_q;
    assign id.read_data1   = rd1_q;
    assign id.read_data2   = rd2_q;
    assign id.sign_ext_imm = imm_q;
    assign id.rt_out       = rt_q;
    assign id.rd_out       = rd_q;
    assign id.reg_dst      = ctrl_q.reg_dst;
    assign id.alu_src      = ctrl_q.alu_src;
    assign id.mem_to_reg   = ctrl_q.mem_to_reg;
    assign id.reg_write    = ctrl_q.reg_write;
    assign id.mem_read     = ctrl_q.mem_read;
    assign id.mem_write    = ctrl_q.mem_write;
    assign id.branch       = ctrl_q.branch;
    assign id.alu_op       = ctrl_q.alu_op;
endmodule

// File: tb/tb_instr_decode.sv
// Randomized scoreboard bench for instr_decode against a behavioural decode/regfile model.
module tb_instr_decode;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    instr_decode_if bus ();
    instr_decode dut (.clk(clk), .reset(reset), .id(bus));

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [8:0]  ctrl;  // reg_dst,alu_src,mem_to_reg,reg_write,mem_read,mem_write,branch,alu_op[1:0]
    } obs_t;

    obs_t        exp_q[$];
    obs_t        held;
    logic [31:0] mregs [32];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [8:0] ref_ctrl(input logic [5:0] op);
        case (op)
            6'h00:   return 9'b1001000_10;
            6'h23:   return 9'b0111100_00;
            6'h2B:   return 9'b0100010_00;
            6'h04:   return 9'b0000001_01;
            6'h08:   return 9'b0101000_00;
            default: return 9'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] a, input logic we,
                                             input logic [4:0] wr, input logic [31:0] wd);
        if (a == 0) return 32'h0;
        if (we && wr == a) return wd;
        return mregs[a];
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.pc   = bus.pc_next_out;
        o.rd1  = bus.read_data1;
        o.rd2  = bus.read_data2;
        o.imm  = bus.sign_ext_imm;
        o.rt   = bus.rt_out;
        o.rd   = bus.rd_out;
        o.ctrl = {bus.reg_dst, bus.alu_src, bus.mem_to_reg, bus.reg_write, bus.mem_read,
                  bus.mem_write, bus.branch, bus.alu_op};
        return o;
    endfunction

    task automatic report(input string name, input obs_t got, input obs_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got pc=%h rd1=%h rd2=%h imm=%h rt=%0d rd=%0d ctrl=%b want pc=%h rd1=%h rd2=%h imm=%h rt=%0d rd=%0d ctrl=%b",
                     name, got.pc, got.rd1, got.rd2, got.imm, got.rt, got.rd, got.ctrl,
                     want.pc, want.rd1, want.rd2, want.imm, want.rt, want.rd, want.ctrl);
        end
    endtask

    // One cycle of stimulus: drive, predict the post-edge ID/EX contents, update model regfile.
    task automatic step(input logic [31:0] ins, input logic st, input logic fl,
                        input logic we, input logic [4:0] wr, input logic [31:0] wd);
        obs_t nxt;
        logic [31:0] pc;
        @(posedge clk); #3;
        pc = $urandom;
        bus.pc_next_in    = pc;
        bus.instruction   = ins;
        bus.stall         = st;
        bus.flush         = fl;
        bus.reg_write_wb  = we;
        bus.write_reg_wb  = wr;
        bus.write_data_wb = wd;
        nxt.pc   = pc;
        nxt.rd1  = ref_read(ins[25:21], we, wr, wd);
        nxt.rd2  = ref_read(ins[20:16], we, wr, wd);
        nxt.imm  = {{16{ins[15]}}, ins[15:0]};
        nxt.rt   = ins[20:16];
        nxt.rd   = ins[15:11];
        nxt.ctrl = fl ? 9'b0 : ref_ctrl(ins[31:26]);
        if (fl || !st) held = nxt;
        exp_q.push_back(held);
        if (we && wr != 0) mregs[wr] = wd;
    endtask

    task automatic idle_inputs();
        bus.pc_next_in = '0; bus.instruction = '0; bus.stall = 0; bus.flush = 0;
        bus.reg_write_wb = 0; bus.write_reg_wb = '0; bus.write_data_wb = '0;
    endtask

    // Reset asserted mid-cycle; outputs must clear without waiting for a clock edge.
    task automatic mid_reset();
        @(posedge clk); #5;
        reset = 1'b1;
        #1 report("async_reset_outputs", sample(), obs_t'('0));
        idle_inputs();
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        held = '0;
        repeat (2) @(posedge clk);
        #5 reset = 1'b0;
        #1 report("reset_release_hold", sample(), obs_t'('0));
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk); #1;
            if (exp_q.size() > 0) report("idex", sample(), exp_q.pop_front());
        end
    end

    initial begin : driver
        logic [5:0]  ops [6];
        logic [31:0] ins;
        logic [4:0]  wr;
        ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h04; ops[4] = 6'h08; ops[5] = 6'h3F;
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        held = '0;
        idle_inputs();
        #2 report("reset_state", sample(), obs_t'('0));
        @(posedge clk); #5 reset = 1'b0;

        // add r4,r5,r6 after writing r5
        step(32'h0, 0, 0, 1, 5'd5, 32'h0000_1234);
        step(32'h00A62020, 0, 0, 0, 5'd0, 32'h0);
        // lw r2,-4(r1)
        step(32'h8C22FFFC, 0, 0, 0, 5'd0, 32'h0);
        // same-cycle write-back bypass of r7
        step(32'h00E00020, 0, 0, 1, 5'd7, 32'hDEAD_BEEF);
        // r0 stays zero, both via bypass path and stored path
        step(32'h00000020, 0, 0, 1, 5'd0, 32'hFFFF_FFFF);
        step(32'h00000020, 0, 0, 0, 5'd0, 32'h0);
        // sw held, stall with beq, then stall+flush
        step(32'hAC450008, 0, 0, 0, 5'd0, 32'h0);
        step(32'h10A6FFFE, 1, 0, 1, 5'd9, 32'h0BAD_F00D);
        step(32'h10A6FFFE, 1, 1, 0, 5'd0, 32'h0);
        step(32'h01290020, 0, 0, 0, 5'd0, 32'h0);
        // r3 write then asynchronous reset; r3 must read back zero
        step(32'h0, 0, 0, 1, 5'd3, 32'h0000_0055);
        mid_reset();
        step(32'h00631820, 0, 0, 0, 5'd0, 32'h0);

        for (int n = 0; n < 300; n++) begin
            ins = {ops[$urandom_range(0, 5)], 26'($urandom)};
            if (ins[31:26] == 6'h3F) ins[31:26] = 6'($urandom);
            wr = ($urandom_range(0, 2) == 0) ? ins[25:21] : 5'($urandom);
            step(ins, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 1) == 1, wr, $urandom);
            if (n == 150) begin
                step(32'h0, 0, 0, 1, 5'd3, 32'h0000_0055);
                mid_reset();
            end
        end

        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
